audio_in_note_detector: RTL and testbench
=========================================

// Module: audio_in_note_detector
// PURPOSE
// Receive-side counterpart of the switch-driven square-wave tone path: reads left-channel samples
// from Audio_Controller's ADC FIFO and measures the period between rising zero crossings.
// Classifies the period against the 10 keyboard notes C4..E5, index 0..9 = SW[0]..SW[9].
// Debounces the result and reports it as a stable note index.
// Sits beside Audio_Controller, driving its read_audio_in and consuming audio_in_available.
// PARAMETERS
// THRESH      32'sd1000000  hysteresis magnitude; arm below -THRESH, edge above +THRESH
// TIMEOUT     20'd400000    cycles without an edge before note is cleared (8 ms @ 50 MHz)
// MATCH_COUNT 2             consecutive identical classifications needed to update note_idx
// PORTS
// CLOCK_50           in   1   system clock, 50 MHz
// resetn             in   1   asynchronous active-low reset
// audio_in_available in   1   Audio_Controller: ADC FIFO holds a sample
// left_channel_in    in   32  Audio_Controller left_channel_audio_in, signed two's complement
// read_audio_in      out  1   one-cycle pop strobe to Audio_Controller
// period             out  20  last measured full period in CLOCK_50 cycles
// period_valid       out  1   one-cycle pulse when period updates
// note_idx           out  4   debounced note 0..9; 4'hF = none / out of range
// note_valid         out  1   high while note_idx holds a note 0..9
// BEHAVIOUR
// Reset (async, resetn=0): read_audio_in=0, period=0, period_valid=0, note_idx=4'hF, note_valid=0.
// Reset also clears: state=NO_REF, arm=0, cycle counter=0, match counter=0, candidate=4'hF.
// Read handshake: if audio_in_available=1 and read_audio_in=0 in cycle t:
//   read_audio_in=1 in cycle t+1; sample latched at the same edge.
//   read_audio_in is never high two cycles in a row, so the max pop rate is one per 2 cycles.
// Crossing detection on the latched sample, evaluated the cycle after the latch:
//   sample < -THRESH -> arm=1.
//   sample > +THRESH with arm=1 -> rising edge; arm=0.
//   Samples within [-THRESH,+THRESH] change nothing. Comparisons are signed.
// Cycle counter: +1 every clock; saturates at TIMEOUT; reset to 1 on an edge (edge cycle counts as 1).
// FSM:
//   NO_REF: first edge -> MEASURING, counter restarts; no period output.
//   MEASURING, edge: period<=counter, period_valid pulses 1 cycle, classify, counter restarts.
//   MEASURING, counter==TIMEOUT and no edge: -> NO_REF; note_idx=F, note_valid=0, match cleared.
//   Edge in the same cycle counter reaches TIMEOUT: edge wins (treated as a normal measurement).
// Classification, unsigned, full period P in cycles:
//   P<70000 or P>200000 -> F.
//   P>=180688 -> 0 (C4)    >=160975 -> 1 (D4)    >=147429 -> 2 (E4)    >=135362 -> 3 (F4)
//   >=120594 -> 4 (G4)     >=107438 -> 5 (A4)    >=98398 -> 6 (B4)     >=90346 -> 7 (C5)
//   >=80490 -> 8 (D5)      else -> 9 (E5)
// Debounce:
//   class==candidate -> match count +1 (saturating).
//   class!=candidate -> candidate=class, match count=1.
//   When match count reaches MATCH_COUNT: note_idx<=candidate; note_valid<=(candidate!=F).
//   Takes effect the cycle after period_valid.
// Counter widths: 20-bit period/counter; TIMEOUT must be < 2^20.
// TESTING
// 1 Reset mid-measurement: resetn=0 -> all outputs at reset values next edge; the first post-reset
//   edge yields no period_valid.
// 2 A4: +/-2e7 square wave, period 113636 cycles, samples offered every 1042 cycles ->
//   period within +/-1042 of 113636; note_idx=5, note_valid=1 after the 3rd rising edge.
// 3 Hysteresis: +/-5e5 sine (below THRESH) -> no period_valid ever; note_valid stays 0.
// 4 Change C4->E5: C4 then 75844-cycle waveform -> one E5 period leaves note_idx=0;
//   second gives note_idx=9.
// 5 Stop tone, samples held at 0 -> note_idx=F, note_valid=0 exactly TIMEOUT cycles after
//   the last edge.
// 6 Handshake: audio_in_available held 1 continuously -> read_audio_in toggles 1,0,1,0;
//   never two consecutive highs.

Source files
------------

// File: rtl/audio_in_note_detector.sv
// Pops left-channel ADC samples, times rising zero crossings with hysteresis,
// classifies the period as one of ten keyboard notes and debounces the result.
module audio_in_note_detector #(
   parameter logic signed [31:0] THRESH      = 32'sd1000000,
   parameter logic [19:0]        TIMEOUT     = 20'd400000,
   parameter int                 MATCH_COUNT = 2,
   parameter int                 PSHIFT      = 0
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               audio_in_available,
   input  logic signed [31:0] left_channel_in,
   output logic               read_audio_in,
   output logic [19:0]        period,
   output logic               period_valid,
   output logic [3:0]         note_idx,
   output logic               note_valid
);

   // PSHIFT scales every period boundary down by a power of two (0 = 50 MHz keyboard table)
   localparam logic [19:0] B_LO = 20'(32'd70000  >> PSHIFT);
   localparam logic [19:0] B_HI = 20'(32'd200000 >> PSHIFT);
   localparam logic [19:0] B_0  = 20'(32'd180688 >> PSHIFT);
   localparam logic [19:0] B_1  = 20'(32'd160975 >> PSHIFT);
   localparam logic [19:0] B_2  = 20'(32'd147429 >> PSHIFT);
   localparam logic [19:0] B_3  = 20'(32'd135362 >> PSHIFT);
   localparam logic [19:0] B_4  = 20'(32'd120594 >> PSHIFT);
   localparam logic [19:0] B_5  = 20'(32'd107438 >> PSHIFT);
   localparam logic [19:0] B_6  = 20'(32'd98398  >> PSHIFT);
   localparam logic [19:0] B_7  = 20'(32'd90346  >> PSHIFT);
   localparam logic [19:0] B_8  = 20'(32'd80490  >> PSHIFT);
   localparam logic [3:0]  MATCH_N = 4'(MATCH_COUNT);

   typedef enum logic {NO_REF = 1'b0, MEASURING = 1'b1} state_t;

   function automatic logic [3:0] classify(input logic [19:0] p);
      logic [3:0] c;
      if (p < B_LO || p > B_HI) c = 4'hF;
      else if (p >= B_0) c = 4'd0;
      else if (p >= B_1) c = 4'd1;
      else if (p >= B_2) c = 4'd2;
      else if (p >= B_3) c = 4'd3;
      else if (p >= B_4) c = 4'd4;
      else if (p >= B_5) c = 4'd5;
      else if (p >= B_6) c = 4'd6;
      else if (p >= B_7) c = 4'd7;
      else if (p >= B_8) c = 4'd8;
      else c = 4'd9;
      return c;
   endfunction

   state_t             state_q, state_d;
   logic               rd_q, rd_d, smp_vld_q, smp_vld_d, arm_q, arm_d, pv_q, pv_d, nv_q, nv_d;
   logic signed [31:0] smp_q, smp_d;
   logic [19:0]        cnt_q, cnt_d, period_q, period_d;
   logic [3:0]         cand_q, cand_d, match_q, match_d, note_q, note_d;
   logic               neg_s, pos_s, edge_s;
   logic [3:0]         cls_s;

   assign neg_s  = smp_vld_q && (smp_q < -THRESH);
   assign pos_s  = smp_vld_q && (smp_q > THRESH);
   assign edge_s = pos_s && arm_q;
   assign cls_s  = classify(cnt_q);

   // next-state: handshake, hysteresis, period counter, FSM and debounce
   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      pv_d      = 1'b0;
      cand_d    = cand_q;
      match_d   = match_q;
      note_d    = note_q;
      nv_d      = nv_q;
      rd_d      = audio_in_available && !rd_q;
      smp_vld_d = rd_d;
      if (rd_d) smp_d = left_channel_in;
      else smp_d = smp_q;
      if (neg_s) arm_d = 1'b1;
      else if (edge_s) arm_d = 1'b0;
      else arm_d = arm_q;
      if (edge_s) cnt_d = 20'd1;
      else if (cnt_q >= TIMEOUT) cnt_d = TIMEOUT;
      else cnt_d = cnt_q + 20'd1;
      // debounce outcome is applied one cycle after the period pulse
      if (pv_q && match_q == MATCH_N) begin
         note_d = cand_q;
         nv_d   = (cand_q != 4'hF);
      end else begin
         note_d = note_q;
         nv_d   = nv_q;
      end
      case (state_q)
         NO_REF: begin
            if (edge_s) state_d = MEASURING;
            else state_d = NO_REF;
         end
         MEASURING: begin
            if (edge_s) begin
               period_d = cnt_q;
               pv_d     = 1'b1;
               if (cls_s == cand_q) begin
                  if (match_q < MATCH_N) match_d = match_q + 4'd1;
                  else match_d = match_q;
               end else begin
                  cand_d  = cls_s;
                  match_d = 4'd1;
               end
            end else if (cnt_q == TIMEOUT) begin
               state_d = NO_REF;
               note_d  = 4'hF;
               nv_d    = 1'b0;
               match_d = 4'd0;
            end else begin
               state_d = MEASURING;
            end
         end
         default: state_d = NO_REF;
      endcase
   end

   // state and output registers
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q   <= NO_REF;
         rd_q      <= 1'b0;
         smp_vld_q <= 1'b0;
         smp_q     <= 32'sd0;
         arm_q     <= 1'b0;
         cnt_q     <= 20'd0;
         period_q  <= 20'd0;
         pv_q      <= 1'b0;
         cand_q    <= 4'hF;
         match_q   <= 4'd0;
         note_q    <= 4'hF;
         nv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         smp_vld_q <= smp_vld_d;
         smp_q     <= smp_d;
         arm_q     <= arm_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         pv_q      <= pv_d;
         cand_q    <= cand_d;
         match_q   <= match_d;
         note_q    <= note_d;
         nv_q      <= nv_d;
      end
   end

   assign read_audio_in = rd_q;
   assign period        = period_q;
   assign period_valid  = pv_q;
   assign note_idx      = note_q;
   assign note_valid    = nv_q;

endmodule

// File: tb/tb_audio_in_note_detector.sv
// Bench for audio_in_note_detector: period boundaries scaled by 2^7, short timeout,
// expected periods queued when an edge is stimulated and compared on period_valid.
module tb_audio_in_note_detector;

   localparam logic signed [31:0] TH = 32'sd1000000;
   localparam int unsigned        TO = 32'd2000;

   logic               clk = 1'b0;
   logic               resetn;
   logic               avail;
   logic signed [31:0] left;
   logic               read_audio_in;
   logic [19:0]        period;
   logic               period_valid;
   logic [3:0]         note_idx;
   logic               note_valid;

   audio_in_note_detector #(
      .THRESH(TH), .TIMEOUT(20'd2000), .MATCH_COUNT(2), .PSHIFT(7)
   ) dut (
      .CLOCK_50(clk), .resetn(resetn), .audio_in_available(avail),
      .left_channel_in(left), .read_audio_in(read_audio_in), .period(period),
      .period_valid(period_valid), .note_idx(note_idx), .note_valid(note_valid)
   );

   always #5 clk = ~clk;

   typedef struct { int unsigned per; logic chk; logic [3:0] note; } sb_t;
   typedef struct { int unsigned per; logic [3:0] note; } vec_t;

   sb_t         sb_q[$];
   vec_t        vecs[19];
   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc = 0;
   bit          m_arm = 1'b0;
   bit          m_ref = 1'b0;
   int unsigned m_last = 0;
   int unsigned edge_cnt = 0;
   bit          chk_next = 1'b0;
   logic [3:0]  exp_next = 4'hF;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // offer one sample for one cycle; model hysteresis and queue the period it must produce
   task automatic offer(input logic signed [31:0] v);
      avail = 1'b1;
      left  = v;
      if (v < -TH) m_arm = 1'b1;
      else if (v > TH && m_arm) begin
         m_arm = 1'b0;
         if (m_ref && (cyc - m_last) <= TO) sb_q.push_back('{cyc - m_last, chk_next, exp_next});
         m_ref  = 1'b1;
         m_last = cyc;
         edge_cnt++;
      end
      chk_next = 1'b0;
      @(negedge clk);
      avail = 1'b0;
   endtask

   // rising edges exactly p cycles apart
   task automatic run_period(input int p, input bit c, input logic [3:0] n);
      idle(2);
      offer(-32'sd20000000);
      idle(p - 4);
      chk_next = c;
      exp_next = n;
      offer(32'sd20000000);
   endtask

   task automatic model_reset();
      m_arm    = 1'b0;
      m_ref    = 1'b0;
      edge_cnt = 0;
      sb_q.delete();
   endtask

   // scoreboard consumer
   initial forever begin
      sb_t e;
      @(negedge clk);
      if (resetn && period_valid) begin
         if (sb_q.size() == 0) chk("unexpected_period_valid", 32'd1, 32'd0);
         else begin
            e = sb_q.pop_front();
            chk("period", 32'(period), e.per);
            if (e.chk) begin
               @(negedge clk);
               chk("note_idx", 32'(note_idx), 32'(e.note));
               chk("note_valid", 32'(note_valid), 32'(e.note != 4'hF));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int d, cnt;
      bit got;
      logic signed [31:0] sine [8];
      sine = '{32'sd0, 32'sd353553, 32'sd500000, 32'sd353553,
               32'sd0, -32'sd353553, -32'sd500000, -32'sd353553};
      vecs = '{'{32'd1600, 4'hF}, '{32'd1562, 4'd0}, '{32'd1563, 4'hF}, '{32'd1411, 4'd0},
               '{32'd1410, 4'd1}, '{32'd1257, 4'd1}, '{32'd1151, 4'd2}, '{32'd1150, 4'd3},
               '{32'd1057, 4'd3}, '{32'd942,  4'd4}, '{32'd941,  4'd5}, '{32'd839,  4'd5},
               '{32'd768,  4'd6}, '{32'd705,  4'd7}, '{32'd704,  4'd8}, '{32'd628,  4'd8},
               '{32'd627,  4'd9}, '{32'd546,  4'd9}, '{32'd545,  4'hF}};
      resetn = 1'b0;
      avail  = 1'b0;
      left   = 32'sd0;
      idle(3);
      chk("rst_read", 32'(read_audio_in), 32'd0);
      chk("rst_period", 32'(period), 32'd0);
      chk("rst_pv", 32'(period_valid), 32'd0);
      chk("rst_note_idx", 32'(note_idx), 32'hF);
      chk("rst_note_valid", 32'(note_valid), 32'd0);
      resetn = 1'b1;

      // reset in the middle of a C4 measurement
      run_period(1484, 1'b0, 4'hF);
      run_period(1484, 1'b0, 4'hF);
      run_period(1484, 1'b1, 4'd0);
      idle(300);
      resetn = 1'b0;
      @(negedge clk);
      chk("mid_rst_period", 32'(period), 32'd0);
      chk("mid_rst_note_idx", 32'(note_idx), 32'hF);
      chk("mid_rst_note_valid", 32'(note_valid), 32'd0);
      chk("mid_rst_read", 32'(read_audio_in), 32'd0);
      model_reset();
      idle(2);
      resetn = 1'b1;

      // A4 square wave sampled every 8 cycles; first edge after reset has no period
      for (int t = 0; t < 4 * 887; t += 8) begin
         chk_next = (edge_cnt == 1 || edge_cnt == 2);
         exp_next = (edge_cnt == 2) ? 4'd5 : 4'hF;
         offer(((t % 887) < 443) ? -32'sd20000000 : 32'sd20000000);
         idle(7);
      end
      idle(5);
      d = int'(period) - 887;
      chk("a4_period_tol", 32'((d <= 8 && d >= -8) ? 1 : 0), 32'd1);
      chk("a4_note_idx", 32'(note_idx), 32'd5);

      // C4 then E5: the first E5 period keeps C4, the second switches
      run_period(1484, 1'b0, 4'hF);
      run_period(1484, 1'b0, 4'hF);
      run_period(1484, 1'b1, 4'd0);
      run_period(592, 1'b1, 4'd0);
      run_period(592, 1'b1, 4'd9);

      // tone stops: note cleared exactly TIMEOUT cycles after the last period pulse
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (period_valid) begin got = 1'b1; break; end
      end
      chk("timeout_pv_seen", 32'(got), 32'd1);
      cnt = 0;
      for (int i = 0; i < 3 * TO; i++) begin
         @(negedge clk);
         cnt++;
         if (!note_valid) break;
      end
      chk("timeout_cycles", 32'(cnt), TO);
      chk("timeout_note_idx", 32'(note_idx), 32'hF);

      // small sine and exact +/-THRESH samples must not arm or fire
      for (int i = 0; i < 40; i++) begin
         offer(sine[i % 8]);
         idle(3);
      end
      offer(-32'sd1000000);  idle(3);
      offer(32'sd1000001);   idle(3);
      offer(-32'sd1000001);  idle(3);
      offer(32'sd1000000);   idle(3);
      chk("hyst_note_valid", 32'(note_valid), 32'd0);
      offer(32'sd1000001);   idle(3);
      offer(-32'sd1000001);  idle(3);
      offer(32'sd1000001);   idle(5);
      chk("hyst_note_idx", 32'(note_idx), 32'hF);

      // availability held high: pop strobe alternates
      avail = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("handshake_read", 32'(read_audio_in), 32'((i % 2) == 0));
      end
      avail = 1'b0;

      // classification boundaries, two periods per vector
      run_period(1000, 1'b0, 4'hF);
      for (int i = 0; i < 19; i++) begin
         run_period(int'(vecs[i].per), 1'b0, 4'hF);
         run_period(int'(vecs[i].per), 1'b1, vecs[i].note);
      end

      // edge exactly at TIMEOUT still measures; one cycle later it does not
      run_period(2000, 1'b1, 4'hF);
      run_period(2001, 1'b0, 4'hF);
      run_period(600, 1'b1, 4'hF);
      run_period(600, 1'b1, 4'd9);

      idle(10);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
